// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle unsigned restoring divider. Produces one quotient
//               bit per clock, WIDTH clocks per division, under a
//               start/busy/done handshake. A zero divisor short-circuits to
//               quotient = all ones, remainder = dividend, div_by_zero = 1
//               on the first RUN edge.
//
// Ports       :
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   start        in   1      division request, sampled only while idle
//   dividend     in   WIDTH  unsigned dividend, sampled on the accept edge
//   divisor      in   WIDTH  unsigned divisor, sampled on the accept edge
//   busy         out  1      division in progress
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  quotient, held until the next completion
//   remainder    out  WIDTH  remainder, held until the next completion
//   div_by_zero  out  1      divisor was zero; cleared on the next accept
//
// Revision    : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Step counter runs 0..WIDTH-1; the step taken while it equals
    // WIDTH-1 is the final one.
    localparam int                 c_cnt_w     = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // The dividend shift register doubles as the quotient register: each
    // step shifts one dividend bit out of the top and one quotient bit in
    // at the bottom, so after WIDTH steps it holds the full quotient.
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_partial;
    logic [c_cnt_w-1:0] r_count;

    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_partial_next;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_div_zero;
    logic               w_last;
    logic               w_accept;
    logic               w_step;
    logic               w_finish;

    // ------------------------------------------------------------------
    // One restoring step.
    // The partial remainder is always below the divisor, so the trial
    // value is below 2*divisor. Hence the (WIDTH+1)-bit subtraction
    // borrows (top bit set) exactly when trial < divisor, and a
    // successful difference always fits back into WIDTH bits. The
    // partial register therefore only needs WIDTH bits of storage.
    // ------------------------------------------------------------------
    assign w_trial        = {r_partial, r_shift[WIDTH-1]};
    assign w_diff         = w_trial - {1'b0, r_divisor};
    assign w_qbit         = ~w_diff[WIDTH];
    assign w_partial_next = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_shift_next   = {r_shift[WIDTH-2:0], w_qbit};
    assign w_div_zero     = (r_divisor == '0);
    assign w_last         = (r_count == c_last_step);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        busy         = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A start on the same cycle that done is high is legal
                // here: the FSM has already returned to IDLE.
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end

            S_RUN: begin
                // start is deliberately not examined: requests while
                // busy, including on the completion edge, are dropped.
                busy = 1'b1;
                if (w_div_zero) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_finish     = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_divisor   <= '0;
            r_partial   <= '0;
            r_count     <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= w_finish;

            if (w_accept) begin
                r_shift     <= dividend;
                r_divisor   <= divisor;
                r_partial   <= '0;
                r_count     <= '0;
                div_by_zero <= 1'b0;
            end

            if (w_step) begin
                r_shift   <= w_shift_next;
                r_partial <= w_partial_next;
                r_count   <= r_count + c_cnt_w'(1);
            end

            if (w_finish) begin
                if (w_div_zero) begin
                    // r_shift has not been stepped yet, so it still
                    // holds the original dividend.
                    quotient    <= '1;
                    remainder   <= r_shift;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient  <= w_shift_next;
                    remainder <= w_partial_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (WIDTH = 4). Directed
//               cases, a reset-abort case, a back-to-back sweep of all
//               operand pairs and a randomized phase, all checked against
//               an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_compared;
    int n_mismatched;

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    seq_divider #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Small shift-and-add 2x2 multiplier model used to cross-check results
    // whose quotient and divisor both fit in two bits.
    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] p;
        p = 4'd0;
        if (y[0]) p = p + {2'b00, x};
        if (y[1]) p = p + {1'b0, x, 1'b0};
        return p;
    endfunction

    // Idle cycles with start low: nothing may be in flight or pulsing.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    // Issue one division at the current negedge and wait for its result.
    // Returns at the negedge where done is observed, with start low, so a
    // following call starts back-to-back on the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
        int           exp_q;
        int           exp_r;
        int           exp_z;
        int           exp_lat;
        int           lat;
        if (b == 0) begin
            exp_q   = (1 << W) - 1;
            exp_r   = a;
            exp_z   = 1;
            exp_lat = 1;
        end else begin
            exp_q   = a / b;
            exp_r   = a % b;
            exp_z   = 0;
            exp_lat = W;
        end

        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", busy, 1);
        check("done_dropped", done, 0);
        check("dbz_cleared", div_by_zero, 0);
        check("q_held", quotient, prev_q);
        check("r_held", remainder, prev_r);

        lat = 0;
        while (1) begin
            if (disturb) begin
                if (lat == 0) begin
                    start    = 1'b1;
                    dividend = 1;
                    divisor  = 1;
                end else begin
                    start    = 1'($urandom_range(0, 1));
                    dividend = W'($urandom);
                    divisor  = W'($urandom);
                end
            end
            @(negedge clk);
            lat++;
            if (done || lat >= 40) break;
            check("run_busy", busy, 1);
        end
        start = 1'b0;

        check("done_seen", done, 1);
        check("latency", lat, exp_lat);
        check("quotient", quotient, exp_q);
        check("remainder", remainder, exp_r);
        check("div_by_zero", div_by_zero, exp_z);
        check("busy_after_done", busy, 0);
        prev_q = W'(exp_q);
        prev_r = W'(exp_r);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        prev_q       = '0;
        prev_r       = '0;
        rst          = 1'b1;
        start        = 1'b0;
        dividend     = '0;
        divisor      = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        idle(2);

        // Directed cases
        run_op(4'd13, 4'd3, 1'b0);
        idle(2);
        run_op(4'd15, 4'd1, 1'b0);
        idle(1);
        run_op(4'd2, 4'd7, 1'b0);
        idle(1);
        run_op(4'd9, 4'd0, 1'b0);
        idle(1);
        run_op(4'd6, 4'd2, 1'b0);
        idle(1);

        // Start and operand changes while busy must be ignored
        run_op(4'd12, 4'd5, 1'b1);
        idle(3);

        // Asynchronous reset two RUN edges into a division
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", quotient, 0);
        check("arst_r", remainder, 0);
        check("arst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_q = '0;
        prev_r = '0;
        idle(6);
        run_op(4'd14, 4'd3, 1'b0);
        idle(1);

        // Back-to-back sweep of every operand pair
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_op(W'(a), W'(b), 1'b0);
                if (b != 0) begin
                    check("inv_sum", 32'(quotient) * 32'(b) + 32'(remainder), a);
                    check("inv_rem_lt", 32'(remainder < W'(b)), 1);
                    if (quotient < 4 && b < 4)
                        check("inv_mul2", 32'(mul2(quotient[1:0], 2'(b))) + 32'(remainder), a);
                end
            end
        end
        idle(1);

        // Randomized phase: random operands, gaps and busy-time disturbance
        for (int k = 0; k < 200; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
